ms_wb_dbg_master: RTL and testbench

Byte-stream to Wishbone bridge acting as a bus initiator. It receives command bytes from a UART receiver over a valid/ready byte stream and issues single classic Wishbone read/write cycles to the user-area slaves (timer, UART, PSRAM, DAC, ADC address windows). It returns status and read data as a response byte stream to a UART transmitter. Gives an external host debug access to the user bus without the management SoC.

---
 rtl/ms_wb_dbg_pkg.sv | 18 +
 rtl/ms_wb_dbg_resp_ser.sv | 49 ++++
 rtl/ms_wb_dbg_master.sv | 145 ++++++++++++++
 tb/tb_ms_wb_dbg_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_wb_dbg_pkg.sv
// rtl/ms_wb_dbg_pkg.sv - shared types and constants for the byte-stream Wishbone debug master
package ms_wb_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } state_e;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TMO     = 8'hEE;
    localparam logic [7:0] CMD_WR_DEF = 8'hA5;
    localparam logic [7:0] CMD_RD_DEF = 8'h5A;
    localparam int         IDX_W      = 2;

endpackage

// File: rtl/ms_wb_dbg_resp_ser.sv
// rtl/ms_wb_dbg_resp_ser.sv - load-and-shift response serializer, up to 5 bytes MSB first
module ms_wb_dbg_resp_ser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic [2:0]  load_cnt,
    input  logic [39:0] load_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        last_xfer
);

    logic [39:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = load_cnt;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            shift_d = {shift_q[31:0], 8'h00};
            cnt_d   = cnt_q - 3'd1;
            valid_d = (cnt_q != 3'd1);
        end
    end

    assign tx_data   = shift_q[39:32];
    assign tx_valid  = valid_q;
    assign last_xfer = valid_q && tx_ready && (cnt_q == 3'd1);

endmodule

// File: rtl/ms_wb_dbg_master.sv
// rtl/ms_wb_dbg_master.sv - byte-stream command decoder driving single classic Wishbone cycles
module ms_wb_dbg_master
    import ms_wb_dbg_pkg::*;
#(
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] CMD_WR  = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD  = CMD_RD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic        busy
);

    localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [CW-1:0]    tmo_q, tmo_d;

    logic        rx_xfer;
    logic        ser_load;
    logic [2:0]  ser_cnt;
    logic [39:0] ser_data;
    logic        last_xfer;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rx_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
    assign rx_xfer  = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        idx_d    = idx_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        tmo_d    = tmo_q;
        ser_load = 1'b0;
        ser_cnt  = we_q ? 3'd1 : 3'd5;
        ser_data = {ST_OK, 32'h0};
        case (state_q)
            IDLE: begin
                if (rx_xfer && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    we_d    = (rx_data == CMD_WR);
                    idx_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rx_xfer) begin
                    adr_d = {adr_q[23:0], rx_data};
                    idx_d = idx_q + 2'd1;
                    tmo_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = we_q ? WDATA : BUS;
                    end
                end
            end
            WDATA: begin
                if (rx_xfer) begin
                    dat_d = {dat_q[23:0], rx_data};
                    idx_d = idx_q + 2'd1;
                    tmo_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                tmo_d = tmo_q + CW'(1);
                // ack wins over a simultaneous timeout expiry
                if (ack_i) begin
                    ser_load = 1'b1;
                    ser_data = {ST_OK, (we_q ? 32'h0 : dat_i)};
                    state_d  = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    ser_load = 1'b1;
                    ser_data = {ST_TMO, 32'h0};
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (last_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cyc_o = (state_q == BUS);
    assign stb_o = cyc_o;
    assign we_o  = cyc_o && we_q;
    assign sel_o = cyc_o ? 4'hF : 4'h0;
    assign adr_o = adr_q;
    assign dat_o = dat_q;
    assign busy  = (state_q != IDLE);

    ms_wb_dbg_resp_ser u_resp_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (ser_load),
        .load_cnt  (ser_cnt),
        .load_data (ser_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_ms_wb_dbg_master.sv
// tb/tb_ms_wb_dbg_master.sv - directed bench with response scoreboard and Wishbone slave model
module tb_ms_wb_dbg_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc_num = 0;
    int last_rx = 0;

    logic [7:0] exp_q[$];

    int          ack_wait = 0;
    logic        never_ack = 1'b0;
    int          wcnt = 0;
    int          cyc_cnt = 0;
    int          bus_bad = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_adr = 32'h0;
    logic [31:0] exp_dat = 32'h0;
    logic        chk_dat = 1'b0;

    ms_wb_dbg_master #(.TIMEOUT(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .busy     (busy)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_num <= cyc_num + 1;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: acks after ack_wait wait states unless never_ack
    always @(negedge clk_i) begin
        if (cyc_o === 1'b1) begin
            cyc_cnt++;
            if (stb_o !== 1'b1 || sel_o !== 4'hF || we_o !== exp_we || adr_o !== exp_adr ||
                (chk_dat && dat_o !== exp_dat))
                bus_bad++;
            ack_i = !never_ack && (wcnt == ack_wait);
            wcnt++;
        end else begin
            ack_i = 1'b0;
            wcnt  = 0;
        end
    end

    // Response monitor: every transfer is checked against the scoreboard
    always @(negedge clk_i) begin
        if (!rst_i && tx_valid === 1'b1 && tx_ready) begin
            if (exp_q.size() == 0)
                chk("tx_unexpected", 40'(exp_q.size()), 40'd1);
            else
                chk("tx_byte", {32'h0, tx_data}, {32'h0, exp_q.pop_front()});
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk_i);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("rx_accept_timeout", 40'(n), 40'd0);
        last_rx = cyc_num;
        @(posedge clk_i);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_done"}, {39'h0, busy}, 40'h0);
        chk({tag, "_drained"}, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic setup_bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input int w, input logic na);
        exp_we = we; exp_adr = a; exp_dat = d; chk_dat = we;
        ack_wait = w; never_ack = na;
        cyc_cnt = 0; bus_bad = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        chk("rst_rx_ready", {39'h0, rx_ready}, 40'h1);
        chk("rst_tx", {31'h0, tx_valid, tx_data}, 40'h0);
        chk("rst_bus", {35'h0, cyc_o, stb_o, we_o, busy, 1'b0}, 40'h0);
        chk("rst_sel", {36'h0, sel_o}, 40'h0);
        chk("rst_adr", {8'h0, adr_o}, 40'h0);
        chk("rst_dat", {8'h0, dat_o}, 40'h0);
        rst_i = 1'b0;

        // write with 2 wait states
        setup_bus(1'b1, 32'h30020004, 32'h11223344, 2, 1'b0);
        exp_q.push_back(8'h00);
        send(8'hA5); send_word(32'h30020004); send_word(32'h11223344);
        wait_idle("write");
        chk("write_cyc_cycles", 40'(cyc_cnt), 40'd3);
        chk("write_bus_signals", 40'(bus_bad), 40'd0);
        chk("write_we_after", {39'h0, we_o}, 40'h0);

        // read, 0-wait, with latency check
        setup_bus(1'b0, 32'h30000008, 32'h0, 0, 1'b0);
        dat_i = 32'hCAFEBABE;
        exp_q.push_back(8'h00); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
        exp_q.push_back(8'hBA); exp_q.push_back(8'hBE);
        send(8'h5A); send_word(32'h30000008);
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("read_latency", 40'(cyc_num - last_rx), 40'd2);
        wait_idle("read");
        chk("read_cyc_cycles", 40'(cyc_cnt), 40'd1);
        chk("read_bus_signals", 40'(bus_bad), 40'd0);

        // read timeout
        setup_bus(1'b0, 32'h40000000, 32'h0, 0, 1'b1);
        exp_q.push_back(8'hEE);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        send(8'h5A); send_word(32'h40000000);
        wait_idle("timeout");
        chk("timeout_cyc_cycles", 40'(cyc_cnt), 40'd4);
        chk("timeout_bus_signals", 40'(bus_bad), 40'd0);

        // garbage bytes followed by a valid write
        setup_bus(1'b1, 32'h10000000, 32'h00000055, 0, 1'b0);
        send(8'h00); send(8'hFF);
        repeat (3) @(negedge clk_i);
        chk("garbage_no_bus", 40'(cyc_cnt), 40'd0);
        chk("garbage_idle", {38'h0, busy, rx_ready}, 40'h1);
        exp_q.push_back(8'h00);
        send(8'hA5); send_word(32'h10000000); send_word(32'h00000055);
        wait_idle("garbage_write");
        chk("garbage_write_cyc", 40'(cyc_cnt), 40'd1);
        chk("garbage_write_bus", 40'(bus_bad), 40'd0);

        // timed-out write held off by tx backpressure
        setup_bus(1'b1, 32'h20000010, 32'hA1B2C3D4, 0, 1'b1);
        tx_ready = 1'b0;
        exp_q.push_back(8'hEE);
        send(8'hA5); send_word(32'h20000010); send_word(32'hA1B2C3D4);
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_tx", {31'h0, tx_valid, tx_data}, {31'h0, 1'b1, 8'hEE});
            chk("stall_rx_ready", {39'h0, rx_ready}, 40'h0);
            @(negedge clk_i);
        end
        tx_ready = 1'b1;
        wait_idle("stall");
        chk("stall_cyc_cycles", 40'(cyc_cnt), 40'd4);

        // reset while the bus cycle is open
        setup_bus(1'b0, 32'h50000010, 32'h0, 0, 1'b1);
        send(8'h5A); send_word(32'h50000010);
        n = 0;
        while (cyc_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("prereset_cyc", {39'h0, cyc_o}, 40'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_bus", {36'h0, cyc_o, stb_o, we_o, busy}, 40'h0);
        chk("async_rst_rx", {38'h0, rx_ready, tx_valid}, 40'h2);
        chk("async_rst_adr", {8'h0, adr_o}, 40'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        setup_bus(1'b0, 32'h50000010, 32'h0, 1, 1'b0);
        dat_i = 32'hDEADBEEF;
        exp_q.push_back(8'h00); exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        send(8'h5A); send_word(32'h50000010);
        wait_idle("post_reset_read");
        chk("post_reset_cyc", 40'(cyc_cnt), 40'd2);
        chk("post_reset_bus", 40'(bus_bad), 40'd0);

        // ack in the final allowed BUS cycle
        setup_bus(1'b0, 32'h60000000, 32'h0, 3, 1'b0);
        dat_i = 32'h12345678;
        exp_q.push_back(8'h00); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        send(8'h5A); send_word(32'h60000000);
        wait_idle("boundary");
        chk("boundary_cyc", 40'(cyc_cnt), 40'd4);
        chk("boundary_bus", 40'(bus_bad), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
